systolic_job_scheduler: RTL and testbench
=========================================

# systolic_job_scheduler

Round-robin scheduler that shares one systolic matrix-multiply array among NUM_REQ requesters. It accepts one job (operand matrices A and B) at a time from a requester and latches the operands. It then pulses the array reset, holds the array start for a fixed compute window and captures the result. The result goes out on a single tagged response channel. It sits between the client ports and the array, and owns the array's start and reset pins.

## Interface
- NUM_REQ, 4: number of requesters (≥2).
- N, 3: matrix dimension, matched to the array.
- DATA_WIDTH, 16: element width, matched to the array.
- ARR_LAT, 2*N+1: cycles arr_start is held high per job. Must be ≥2*N so the array has captured its result.
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  [NUM_REQ]  job request per requester.
- req_ready  out  [NUM_REQ]  one-hot grant/accept pulse.
- req_a, req_b  in  [NUM_REQ][N][N]×DATA_WIDTH  operands per requester.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the result.
- rsp_c  out  [N][N]×DATA_WIDTH  result matrix.
- arr_reset  out  1  active-high reset to the array.
- arr_start  out  1  start to the array.
- arr_matrix_a, arr_matrix_b  out  [N][N]×DATA_WIDTH  latched operands to the array.
- arr_matrix_c  in  [N][N]×DATA_WIDTH  array result.
- busy  out  1  high in any state other than IDLE.
- jobs_done  out  16  count of completed responses; wraps modulo 2^16.

## Operation
- States:
  - IDLE → ARR_RST on a grant.
  - ARR_RST → RUN unconditionally.
  - RUN → RSP when run_cnt == ARR_LAT-1.
  - RSP → IDLE when rsp_ready is high.
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs, except req_ready (see below).
- Arbitration, IDLE only:
  - Scan requesters starting at pointer ptr, wrapping around; grant the first one with req_valid=1.
  - req_ready[g]=1 for that single cycle. This is the handshake: req_a[g]/req_b[g] are latched into the operand registers, g into rsp_id, and ptr ← (g+1) mod NUM_REQ.
  - req_ready is a combinational decode of state, ptr and req_valid. It is zero outside IDLE.
- ARR_RST: arr_reset=1 for exactly one cycle. This clears the array's cycle counter and result, which is mandatory before every job.
- RUN:
  - arr_start=1 and run_cnt counts 0..ARR_LAT-1.
  - On the edge leaving RUN, arr_matrix_c is captured into rsp_c.
  - arr_start drops to 0 in RSP, which returns the array to its idle state.
- RSP:
  - rsp_valid=1; rsp_c and rsp_id are stable until the handshake.
  - On rsp_valid & rsp_ready: jobs_done increments and the FSM goes to IDLE.
- arr_matrix_a/b hold the latched operands from grant until the next grant.
- req_valid dropping after its grant has no effect on the job in flight.

## Timing
- Reset values (reset_n low, async): state=IDLE, ptr=0, run_cnt=0, all req_ready=0, rsp_valid=0, rsp_id=0, rsp_c=0, arr_reset=0, arr_start=0, arr_matrix_a/b=0, busy=0, jobs_done=0.
- Handshake in cycle T:
  - arr_reset high in T+1.
  - arr_start high in T+2 … T+1+ARR_LAT.
  - rsp_valid high from T+2+ARR_LAT.
  - Default latency T→rsp_valid: 9 cycles for N=3.
- rsp_ready high in the first RSP cycle gives a 1-cycle RSP. The earliest next grant is the cycle after that, so back-to-back jobs take ARR_LAT+3 cycles each.
- rsp_ready held low: RSP is held indefinitely, and no new grant is issued.
- Simultaneous requests: exactly one grant per IDLE cycle; losers wait with req_valid held.
- ptr wraps from NUM_REQ-1 to 0.
- If only the requester at ptr-1 is valid, it is granted after a full scan in the same cycle. No idle cycles are inserted.
- reset_n asserted mid-RUN or mid-RSP: immediate return to the reset values, the in-flight job is discarded, and no response is issued.
- jobs_done wraps from 0xFFFF to 0.

## Test plan
- Reset, then a single job. Requester 2 sends A=[[1,2,3],[4,5,6],[7,8,9]], B=identity. Required: req_ready[2] for 1 cycle; arr_reset for 1 cycle; arr_start for 7 cycles; rsp_valid 9 cycles after the handshake with rsp_id=2, rsp_c=A; jobs_done=1.
- All four requesters valid continuously, rsp_ready=1. Required grant order 0,1,2,3,0; grants spaced 10 cycles apart.
- Back-to-back jobs through one array. Job 1 uses B=identity; job 2 uses A=identity, B=[[2,0,0],[0,2,0],[0,0,2]]. Required: job 2 rsp_c=diag(2,2,2), i.e. no residue from job 1 (confirms the array is reset per job).
- rsp_ready held low for 20 cycles. Required: rsp_valid, rsp_c and rsp_id stable; no req_ready; busy=1. Release rsp_ready → IDLE the next cycle.
- reset_n pulsed low at the 4th RUN cycle. Required: arr_start=0 and rsp_valid=0 immediately; jobs_done=0; no response for the aborted job. A fresh job afterwards completes normally.
- With ptr=1, only requester 0 is valid. Required: requester 0 granted in that same cycle, and ptr becomes 1.

Source files
------------

// File: rtl/systolic_job_scheduler.sv
// systolic_job_scheduler
//   Shares one systolic matrix-multiply array among NUM_REQ requesters.
//   A round-robin arbiter accepts one job at a time in IDLE and latches its
//   operands. The FSM then pulses the array reset for one cycle and holds the
//   array start for ARR_LAT cycles. It captures the array result and offers it
//   on a single tagged response channel.
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid / req_ready      per-requester request / one-hot accept pulse
//   req_a, req_b               per-requester operand matrices
//   rsp_valid / rsp_ready      response handshake
//   rsp_id, rsp_c              owner of the result, result matrix
//   arr_reset, arr_start       array control pins
//   arr_matrix_a/b, arr_matrix_c  operands to the array, result from the array
//   busy                       FSM not in IDLE
//   jobs_done                  completed-response counter (wraps)

module systolic_job_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int N          = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ARR_LAT    = 2*N+1,
  localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNTW      = (ARR_LAT > 1) ? $clog2(ARR_LAT) : 1
) (
  input  logic                                               clk,
  input  logic                                               reset_n,
  input  logic [NUM_REQ-1:0]                                 req_valid,
  output logic [NUM_REQ-1:0]                                 req_ready,
  input  logic [NUM_REQ-1:0][N-1:0][N-1:0][DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][N-1:0][N-1:0][DATA_WIDTH-1:0]   req_b,
  output logic                                               rsp_valid,
  input  logic                                               rsp_ready,
  output logic [IDW-1:0]                                     rsp_id,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]                rsp_c,
  output logic                                               arr_reset,
  output logic                                               arr_start,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]                arr_matrix_a,
  output logic [N-1:0][N-1:0][DATA_WIDTH-1:0]                arr_matrix_b,
  input  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]                arr_matrix_c,
  output logic                                               busy,
  output logic [15:0]                                        jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARR_RST = 2'd1,
    S_RUN     = 2'd2,
    S_RSP     = 2'd3
  } state_t;

  state_t                                 state_q, state_d;
  logic [IDW-1:0]                         ptr_q, ptr_d;
  logic [CNTW-1:0]                        run_cnt_q, run_cnt_d;
  logic [IDW-1:0]                         rsp_id_q, rsp_id_d;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]    rsp_c_q, rsp_c_d;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]    mat_a_q, mat_a_d;
  logic [N-1:0][N-1:0][DATA_WIDTH-1:0]    mat_b_q, mat_b_d;
  logic [15:0]                            jobs_done_q, jobs_done_d;

  logic                                   grant_found;
  logic [IDW-1:0]                         grant_idx;
  int unsigned                            scan_pos;

  // Round-robin scan starting at ptr; the position is wrapped by subtraction
  // so NUM_REQ need not be a power of two.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_pos    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_pos = 32'(ptr_q) + i;
      if (scan_pos >= NUM_REQ) scan_pos = scan_pos - NUM_REQ;
      if (!grant_found && req_valid[IDW'(scan_pos)]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan_pos);
      end
    end
  end

  // The accept pulse is the only output with a combinational path from inputs.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    run_cnt_d   = run_cnt_q;
    rsp_id_d    = rsp_id_q;
    rsp_c_d     = rsp_c_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    jobs_done_d = jobs_done_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          mat_a_d  = req_a[grant_idx];
          mat_b_d  = req_b[grant_idx];
          rsp_id_d = grant_idx;
          ptr_d    = (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + IDW'(1);
          state_d  = S_ARR_RST;
        end
      end
      S_ARR_RST: begin
        run_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (run_cnt_q == CNTW'(ARR_LAT-1)) begin
          rsp_c_d   = arr_matrix_c;
          run_cnt_d = '0;
          state_d   = S_RSP;
        end else begin
          run_cnt_d = run_cnt_q + CNTW'(1);
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          jobs_done_d = jobs_done_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      run_cnt_q   <= '0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      jobs_done_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      run_cnt_q   <= run_cnt_d;
      rsp_id_q    <= rsp_id_d;
      rsp_c_q     <= rsp_c_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      jobs_done_q <= jobs_done_d;
    end
  end

  // Control pins are pure decodes of the state register.
  assign arr_reset    = (state_q == S_ARR_RST);
  assign arr_start    = (state_q == S_RUN);
  assign rsp_valid    = (state_q == S_RSP);
  assign busy         = (state_q != S_IDLE);
  assign rsp_id       = rsp_id_q;
  assign rsp_c        = rsp_c_q;
  assign arr_matrix_a = mat_a_q;
  assign arr_matrix_b = mat_b_q;
  assign jobs_done    = jobs_done_q;

endmodule

// File: tb/tb_systolic_job_scheduler.sv
// tb_systolic_job_scheduler
//   Directed bench for systolic_job_scheduler. A small accumulating array model
//   stands in for the systolic array. It clears on arr_reset and accumulates one
//   rank-1 term per arr_start cycle for N cycles, so a missing per-job reset
//   leaves residue in the result.

module tb_systolic_job_scheduler;

  localparam int NUM_REQ = 4;
  localparam int N       = 3;
  localparam int DW      = 16;
  localparam int ARR_LAT = 2*N+1;

  typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

  logic                                 clk = 1'b0;
  logic                                 reset_n;
  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [NUM_REQ-1:0][N-1:0][N-1:0][DW-1:0] req_a, req_b;
  logic                                 rsp_valid, rsp_ready;
  logic [1:0]                           rsp_id;
  mat_t                                 rsp_c, arr_matrix_a, arr_matrix_b, arr_matrix_c;
  logic                                 arr_reset, arr_start, busy;
  logic [15:0]                          jobs_done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_jobs = 0;

  mat_t m_seq, m_id, m_two;

  systolic_job_scheduler #(
    .NUM_REQ(NUM_REQ), .N(N), .DATA_WIDTH(DW), .ARR_LAT(ARR_LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c(rsp_c),
    .arr_reset(arr_reset), .arr_start(arr_start),
    .arr_matrix_a(arr_matrix_a), .arr_matrix_b(arr_matrix_b),
    .arr_matrix_c(arr_matrix_c),
    .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Array stand-in
  mat_t       arr_c_q;
  logic [3:0] arr_k_q;
  always @(posedge clk) begin
    if (!reset_n || arr_reset) begin
      arr_c_q <= '0;
      arr_k_q <= '0;
    end else if (arr_start && arr_k_q < 4'(N)) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          arr_c_q[i[1:0]][j[1:0]] <= arr_c_q[i[1:0]][j[1:0]]
            + arr_matrix_a[i[1:0]][arr_k_q[1:0]] * arr_matrix_b[arr_k_q[1:0]][j[1:0]];
      arr_k_q <= arr_k_q + 4'd1;
    end
  end
  assign arr_matrix_c = arr_c_q;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    exp_jobs = 0;
  endtask

  // One job from requester r with request mask 'mask'. rsp_ready is held low
  // for 'hold' RSP cycles (all requesters valid meanwhile), then released.
  task automatic do_job(input logic [3:0] mask, input int r, input mat_t a, input mat_t b,
                        input mat_t c, input int hold);
    logic [3:0] exp_g;
    int lat, st, rs;
    exp_g = '0;
    exp_g[r[1:0]] = 1'b1;
    @(negedge clk);
    req_a[r[1:0]] = a;
    req_b[r[1:0]] = b;
    req_valid = mask;
    rsp_ready = 1'b0;
    #1 check("grant", 256'(req_ready), 256'(exp_g));
    @(posedge clk);
    #1 req_valid = '0;
    lat = 0; st = 0; rs = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (arr_reset) rs++;
      if (arr_start) st++;
      if (rsp_valid) begin
        lat = cyc;
        break;
      end
    end
    check("rsp_latency", 256'(lat), 256'(ARR_LAT + 2));
    check("arr_start_cycles", 256'(st), 256'(ARR_LAT));
    check("arr_reset_cycles", 256'(rs), 256'(1));
    check("rsp_id", 256'(rsp_id), 256'(r));
    check("rsp_c", 256'(rsp_c), 256'(c));
    check("arr_matrix_a", 256'(arr_matrix_a), 256'(a));
    check("arr_matrix_b", 256'(arr_matrix_b), 256'(b));
    req_valid = '1;
    for (int h = 0; h < hold; h++) begin
      #1;
      check("hold_req_ready", 256'(req_ready), 256'(0));
      check("hold_rsp_valid", 256'(rsp_valid), 256'(1));
      check("hold_rsp_c", 256'(rsp_c), 256'(c));
      check("hold_rsp_id", 256'(rsp_id), 256'(r));
      check("hold_busy", 256'(busy), 256'(1));
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_jobs++;
    check("idle_busy", 256'(busy), 256'(0));
    check("idle_rsp_valid", 256'(rsp_valid), 256'(0));
    check("jobs_done", 256'(jobs_done), 256'(exp_jobs));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] g_val [5];
    int         g_cyc [5];
    int         ng, seen;

    m_id = '0; m_two = '0;
    for (int i = 0; i < N; i++) begin
      m_id[i[1:0]][i[1:0]]  = 16'd1;
      m_two[i[1:0]][i[1:0]] = 16'd2;
      for (int j = 0; j < N; j++) m_seq[i[1:0]][j[1:0]] = 16'(3*i + j + 1);
    end
    req_a = '0; req_b = '0;
    reset_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;

    // Reset values
    @(negedge clk);
    #1;
    check("rst_req_ready", 256'(req_ready), 256'(0));
    check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    check("rst_arr_start", 256'(arr_start), 256'(0));
    check("rst_arr_reset", 256'(arr_reset), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_jobs_done", 256'(jobs_done), 256'(0));
    check("rst_rsp_c", 256'(rsp_c), 256'(0));
    check("rst_rsp_id", 256'(rsp_id), 256'(0));
    check("rst_arr_matrix_a", 256'(arr_matrix_a), 256'(0));
    apply_reset();

    // Single job from requester 2, C = A * I = A
    do_job(4'b0100, 2, m_seq, m_id, m_seq, 0);

    // Round robin with all requesters valid and rsp_ready high
    apply_reset();
    @(negedge clk);
    req_valid = '1;
    rsp_ready = 1'b1;
    ng = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (req_ready != '0) begin
        g_val[ng] = req_ready;
        g_cyc[ng] = cyc;
        ng++;
        if (ng == 5) break;
      end
      @(negedge clk);
    end
    check("rr_grant_count", 256'(ng), 256'(5));
    for (int k = 0; k < 5; k++) begin
      if (k < ng) begin
        check("rr_order", 256'(g_val[k]), 256'(4'b0001 << (k % 4)));
        if (k > 0) check("rr_spacing", 256'(g_cyc[k] - g_cyc[k-1]), 256'(ARR_LAT + 3));
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (12) @(negedge clk);
    rsp_ready = 1'b0;
    exp_jobs = 5;
    check("rr_jobs_done", 256'(jobs_done), 256'(exp_jobs));
    check("rr_busy", 256'(busy), 256'(0));

    // ptr is 1: lone requester 0 is granted in the same cycle (full scan),
    // then requester 1 wins over 0 since ptr returns to 1. Second job also
    // checks for residue from the first.
    do_job(4'b0001, 0, m_seq, m_id, m_seq, 0);
    do_job(4'b0011, 1, m_id, m_two, m_two, 0);

    // Response stalled for 20 cycles
    do_job(4'b0100, 2, m_id, m_seq, m_seq, 20);

    // Reset in the 4th RUN cycle discards the job
    @(negedge clk);
    req_a[3] = m_seq;
    req_b[3] = m_id;
    req_valid = 4'b1000;
    #1 check("abort_grant", 256'(req_ready), 256'(4'b1000));
    @(posedge clk);
    #1 req_valid = '0;
    repeat (5) @(negedge clk);
    check("abort_in_run", 256'(arr_start), 256'(1));
    reset_n = 1'b0;
    #1;
    check("abort_arr_start", 256'(arr_start), 256'(0));
    check("abort_rsp_valid", 256'(rsp_valid), 256'(0));
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_jobs_done", 256'(jobs_done), 256'(0));
    check("abort_arr_matrix_a", 256'(arr_matrix_a), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    exp_jobs = 0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", 256'(seen), 256'(0));
    do_job(4'b0010, 1, m_seq, m_id, m_seq, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
